// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Holds default widths and reset PC so fetch, decode and instruction
// memory agree on sizes, plus the fetch FSM state type.
package fetch_unit_pkg;

    localparam int unsigned DEF_PC_WIDTH          = 8;
    localparam int unsigned DEF_INSTRUCTION_WIDTH = 16;
    localparam int unsigned DEF_RESET_PC          = 0;
    localparam int unsigned DEF_COUNT_WIDTH       = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours (instruction memory,
// decode, branch unit, halt control).
//   master : fetch side  - drives pc, out_*, halted, fetch_count
//   slave  : environment - drives instruction, out_ready, branch_*, halt
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = DEF_PC_WIDTH,
    parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) ();

    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic [INSTRUCTION_WIDTH-1:0] out_instruction;
    logic [PC_WIDTH-1:0]          out_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic                         branch_valid;
    logic [PC_WIDTH-1:0]          branch_target;
    logic                         halt;
    logic                         halted;
    logic [COUNT_WIDTH-1:0]       fetch_count;

    modport master (
        output pc, out_instruction, out_pc, out_valid, halted, fetch_count,
        input  instruction, out_ready, branch_valid, branch_target, halt
    );

    modport slave (
        input  pc, out_instruction, out_pc, out_valid, halted, fetch_count,
        output instruction, out_ready, branch_valid, branch_target, halt
    );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter register.
//   clock_i / reset_n_i : clock, asynchronous active-low reset
//   load_i / target_i   : redirect; load target (wins over advance)
//   advance_i           : step to the next sequential address (wraps)
//   pc_o                : current program counter
module fetch_pc_register #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] target_i,
    input  logic                advance_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of a combinational instruction memory.
// Owns the PC, registers the returned word and offers it to decode over
// a valid/ready handshake; supports branch redirect, halt/resume and a
// count of words handed to decode.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (master)   : pc/instruction to memory, out_* handshake to decode,
//                    branch_valid/branch_target, halt/halted, fetch_count
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = DEF_PC_WIDTH,
    parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int unsigned RESET_PC          = DEF_RESET_PC,
    parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    fetch_state_t state_q, state_d;

    logic                         out_valid_q, out_valid_d;
    logic [INSTRUCTION_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [PC_WIDTH-1:0]          out_pc_q,    out_pc_d;
    logic [COUNT_WIDTH-1:0]       count_q,     count_d;

    logic [PC_WIDTH-1:0] pc_w;
    logic                flush;
    logic                transfer;
    logic                advance;

    // Redirect outranks everything: it discards the registered word even
    // if decode is accepting it in the same cycle.
    assign flush    = bus.branch_valid;
    assign transfer = out_valid_q && bus.out_ready;
    assign advance  = (state_q == RUN) && !bus.halt && !flush
                      && (!out_valid_q || bus.out_ready);

    fetch_pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (PC_WIDTH'(RESET_PC))
    ) u_pc (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .load_i    (flush),
        .target_i  (bus.branch_target),
        .advance_i (advance),
        .pc_o      (pc_w)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        count_d     = count_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.instruction;
            out_pc_d    = pc_w;
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
        // A flushed word never counts as delivered.
        if (transfer && !flush) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Halt waits for the output register to drain (or drain this cycle)
    // so that halted also means "nothing pending for decode".
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (bus.halt && (!out_valid_q || bus.out_ready)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!bus.halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            count_q     <= count_d;
        end
    end

    assign bus.pc              = pc_w;
    assign bus.out_instruction = out_instr_q;
    assign bus.out_pc          = out_pc_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.halted          = (state_q == HALTED);
    assign bus.fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clock;
    logic reset_n;

    int unsigned checks;
    int unsigned failures;

    // Transaction-level reference: address of the next word decode must
    // see, and how many words decode has accepted.
    logic [7:0]  exp_next;
    logic [15:0] model_count;

    fetch_unit_if #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16), .COUNT_WIDTH(16)) bus ();

    fetch_unit #(
        .PC_WIDTH          (8),
        .INSTRUCTION_WIDTH (16),
        .RESET_PC          (0),
        .COUNT_WIDTH       (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Combinational instruction memory: word = 0x1000 + address.
    assign bus.instruction = 16'h1000 + 16'(bus.pc);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the settled pre-edge state, update the reference
    // from the handshake seen this cycle, cross the edge, check results.
    task automatic tick();
        logic        ov, rdy, br, hl, hd, exp_halted;
        logic [7:0]  opc, pcv, tgt;
        logic [15:0] oin;
        ov  = bus.out_valid;
        rdy = bus.out_ready;
        br  = bus.branch_valid;
        hl  = bus.halt;
        hd  = bus.halted;
        opc = bus.out_pc;
        pcv = bus.pc;
        tgt = bus.branch_target;
        oin = bus.out_instruction;

        if (ov) begin
            chk("seq_out_pc", 32'(opc), 32'(exp_next));
            chk("word_matches_pc", 32'(oin), 32'(16'h1000 + 16'(opc)));
            chk("pc_ahead", 32'(pcv), 32'(8'(opc + 8'd1)));
        end
        if (hd) chk("halted_empty", 32'(ov), 32'd0);

        if (ov && rdy && !br) begin
            model_count = model_count + 16'd1;
            exp_next    = 8'(opc + 8'd1);
        end
        if (br) exp_next = tgt;
        exp_halted = hl && (hd || !ov || rdy);

        @(posedge clock);
        #1;

        chk("fetch_count", 32'(bus.fetch_count), 32'(model_count));
        chk("halted", 32'(bus.halted), 32'(exp_halted));
        if (ov && !rdy && !br) begin
            chk("hold_out_pc", 32'(bus.out_pc), 32'(opc));
            chk("hold_instr", 32'(bus.out_instruction), 32'(oin));
            chk("hold_pc", 32'(bus.pc), 32'(pcv));
        end
        if (br) begin
            chk("flush_valid", 32'(bus.out_valid), 32'd0);
            chk("redirect_pc", 32'(bus.pc), 32'(tgt));
        end
        if (hd && !br) chk("halt_pc_hold", 32'(bus.pc), 32'(pcv));
        if (hd) chk("no_fetch_halted", 32'(bus.out_valid), 32'd0);
        if (!hd && !br && !hl && (!ov || rdy)) chk("advance_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        exp_next      = 8'h00;
        model_count   = 16'h0000;
        reset_n       = 1'b0;
        bus.out_ready     = 1'b1;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.halt          = 1'b0;

        #2;
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_instr", 32'(bus.out_instruction), 32'h0);
        chk("rst_out_pc", 32'(bus.out_pc), 32'h0);
        chk("rst_count", 32'(bus.fetch_count), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        #10;
        reset_n = 1'b1;

        // Streaming from reset, then a 3-cycle stall at out_pc=2.
        tick();
        chk("t1_first_out_pc", 32'(bus.out_pc), 32'h0);
        chk("t1_first_instr", 32'(bus.out_instruction), 32'h1000);
        tick();
        chk("t1_out_pc1", 32'(bus.out_pc), 32'h1);
        tick();
        chk("t1_out_pc2", 32'(bus.out_pc), 32'h2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_out_pc", 32'(bus.out_pc), 32'h2);
            chk("t2_stall_pc", 32'(bus.pc), 32'h3);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("t2_resume_out_pc", 32'(bus.out_pc), 32'h3);
        tick();
        chk("t1_count4", 32'(bus.fetch_count), 32'd4);

        // Redirect while out_pc=5 is valid and accepted.
        tick();
        chk("t3_out_pc5", 32'(bus.out_pc), 32'h5);
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h40;
        tick();
        bus.branch_valid = 1'b0;
        chk("t3_bubble", 32'(bus.out_valid), 32'd0);
        tick();
        chk("t3_target_pc", 32'(bus.out_pc), 32'h40);
        chk("t3_target_instr", 32'(bus.out_instruction), 32'h1040);
        chk("t3_count_no_flush", 32'(bus.fetch_count), 32'd5);

        // Halt with a pending word that decode is not yet accepting.
        bus.out_ready = 1'b0;
        bus.halt      = 1'b1;
        tick();
        tick();
        chk("t4_held_pc", 32'(bus.out_pc), 32'h40);
        chk("t4_held_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_not_halted", 32'(bus.halted), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_drained", 32'(bus.out_valid), 32'd0);
        chk("t4_halted", 32'(bus.halted), 32'd1);
        chk("t4_count", 32'(bus.fetch_count), 32'd6);
        tick();
        bus.halt = 1'b0;
        tick();
        chk("t4_unhalted", 32'(bus.halted), 32'd0);
        tick();
        chk("t4_resume_pc", 32'(bus.out_pc), 32'h41);
        chk("t4_resume_valid", 32'(bus.out_valid), 32'd1);

        // PC wrap at the top of the address space.
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'hFE;
        tick();
        bus.branch_valid = 1'b0;
        tick();
        chk("t5_fe", 32'(bus.out_pc), 32'hFE);
        tick();
        chk("t5_ff", 32'(bus.out_pc), 32'hFF);
        tick();
        chk("t5_00", 32'(bus.out_pc), 32'h00);
        chk("t5_00_instr", 32'(bus.out_instruction), 32'h1000);
        tick();
        chk("t5_01", 32'(bus.out_pc), 32'h01);

        // Asynchronous reset between edges.
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_pc", 32'(bus.pc), 32'h0);
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_count", 32'(bus.fetch_count), 32'd0);
        chk("t6_halted", 32'(bus.halted), 32'd0);
        #2;
        reset_n     = 1'b1;
        exp_next    = 8'h00;
        model_count = 16'h0000;
        tick();
        chk("t6_first_out_pc", 32'(bus.out_pc), 32'h0);
        chk("t6_first_valid", 32'(bus.out_valid), 32'd1);

        // Randomized traffic against the transaction-level reference.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready     = ($urandom_range(0, 3) != 0);
            bus.branch_valid  = ($urandom_range(0, 19) == 0);
            bus.branch_target = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus.halt = !bus.halt;
            tick();
        end
        bus.branch_valid = 1'b0;
        bus.halt         = 1'b0;
        bus.out_ready    = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
